// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates IF fetches and LSB loads/stores onto a byte-wide RAM port.
// Build option: define MEM_ARBITER_RR_EN for round-robin; default is fixed priority (LSB wins ties).
module mem_arbiter #(
    parameter int unsigned ADDR_WID = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                if_valid,
    input  logic [ADDR_WID-1:0] if_addr,
    output logic                if_done,
    output logic [31:0]         if_data,
    input  logic                lsb_valid,
    input  logic                lsb_is_store,
    input  logic [ADDR_WID-1:0] lsb_addr,
    input  logic [2:0]          lsb_len,
    input  logic [31:0]         lsb_data,
    output logic                lsb_done,
    output logic [31:0]         lsb_rdata,
    input  logic [7:0]          mem_din,
    output logic [7:0]          mem_dout,
    output logic [ADDR_WID-1:0] mem_a,
    output logic                mem_wr,
    input  logic                io_buffer_full
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_buf;
    logic [DATA_W-1:0]   r_if_data;
    logic [DATA_W-1:0]   r_lsb_rdata;
    logic [ADDR_WID-1:0] r_mem_a;
    logic [BYTE_W-1:0]   r_mem_dout;
    logic [IDX_W-1:0]    r_last;
    logic [IDX_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_pend_idx;
    logic                r_issuing;
    logic                r_pend;
    logic                r_wr_act;
    logic                r_io_region;
    logic                r_if_done;
    logic                r_lsb_done;

    logic                w_grant_if;
    logic                w_grant_lsb;
    logic                w_io_region;
    logic                w_io_stall;
    logic                w_wr_fire;
    logic                w_fin;
    logic [IDX_W-1:0]    w_len_last;
    logic [IDX_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   w_rd_word;
    logic [BYTE_W-1:0]   w_next_byte;

    // Tie-break between simultaneous requesters
`ifdef MEM_ARBITER_RR_EN
    logic r_last_lsb;
    assign w_grant_lsb = lsb_valid & ~(if_valid & r_last_lsb);
`else
    assign w_grant_lsb = lsb_valid;
`endif
    assign w_grant_if  = if_valid & ~w_grant_lsb;

    generate
        if (ADDR_WID >= 18) begin : g_io
            assign w_io_region = (lsb_addr[17:16] == 2'b11);
        end else begin : g_no_io
            assign w_io_region = 1'b0;
        end
    endgenerate

    assign w_len_last  = (lsb_len == 3'd1) ? 2'd0 :
                         (lsb_len == 3'd2) ? 2'd1 : 2'd3;
    assign w_cnt_nxt   = r_cnt + 2'd1;
    assign w_rd_word   = r_buf | (DATA_W'(mem_din) << {r_pend_idx, 3'b000});
    assign w_next_byte = BYTE_W'(r_wdata >> {w_cnt_nxt, 3'b000});
    assign w_io_stall  = r_io_region & io_buffer_full;
    assign w_wr_fire   = r_wr_act & rdy & ~w_io_stall;
    assign w_fin       = r_if_done | r_lsb_done;

    // Write strobe must drop in the very cycle rdy falls or the IO buffer fills
    assign mem_wr    = w_wr_fire;
    assign mem_a     = r_mem_a;
    assign mem_dout  = r_mem_dout;
    assign if_done   = r_if_done;
    assign if_data   = r_if_data;
    assign lsb_done  = r_lsb_done;
    assign lsb_rdata = r_lsb_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_if_data   <= '0;
            r_lsb_rdata <= '0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_last      <= '0;
            r_cnt       <= '0;
            r_pend_idx  <= '0;
            r_issuing   <= 1'b0;
            r_pend      <= 1'b0;
            r_wr_act    <= 1'b0;
            r_io_region <= 1'b0;
            r_if_done   <= 1'b0;
            r_lsb_done  <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            r_last_lsb  <= 1'b0;
`endif
        end else begin
            r_if_done  <= 1'b0;
            r_lsb_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rdy && !rollback && (w_grant_if || w_grant_lsb)) begin
                        r_mem_a   <= w_grant_lsb ? lsb_addr : if_addr;
                        r_cnt     <= '0;
                        r_issuing <= 1'b1;
                        r_pend    <= 1'b0;
                        r_buf     <= '0;
`ifdef MEM_ARBITER_RR_EN
                        r_last_lsb <= w_grant_lsb;
`endif
                        if (w_grant_lsb) begin
                            r_last      <= w_len_last;
                            r_wdata     <= lsb_data;
                            r_io_region <= w_io_region;
                            if (lsb_is_store) begin
                                r_state    <= STORE;
                                r_mem_dout <= lsb_data[7:0];
                                r_wr_act   <= 1'b1;
                            end else begin
                                r_state <= LOAD;
                            end
                        end else begin
                            r_last  <= 2'd3;
                            r_state <= IFETCH;
                        end
                    end
                end

                IFETCH, LOAD: begin
                    if (w_fin || rollback) begin
                        r_state   <= IDLE;
                        r_issuing <= 1'b0;
                        r_pend    <= 1'b0;
                    end else begin
                        // Byte returning now was addressed last cycle with rdy high
                        if (r_pend) begin
                            r_buf <= w_rd_word;
                            if (r_pend_idx == r_last) begin
                                if (r_state == IFETCH) begin
                                    r_if_done <= 1'b1;
                                    r_if_data <= w_rd_word;
                                end else begin
                                    r_lsb_done  <= 1'b1;
                                    r_lsb_rdata <= w_rd_word;
                                end
                            end
                        end
                        if (rdy && r_issuing) begin
                            r_pend     <= 1'b1;
                            r_pend_idx <= r_cnt;
                            if (r_cnt == r_last) begin
                                r_issuing <= 1'b0;
                            end else begin
                                r_cnt   <= w_cnt_nxt;
                                r_mem_a <= r_mem_a + ADDR_WID'(1);
                            end
                        end else begin
                            r_pend <= 1'b0;
                        end
                    end
                end

                STORE: begin
                    // Rollback never aborts a store once granted
                    if (w_fin) begin
                        r_state <= IDLE;
                    end else if (w_wr_fire) begin
                        if (r_cnt == r_last) begin
                            r_wr_act   <= 1'b0;
                            r_lsb_done <= 1'b1;
                        end else begin
                            r_cnt      <= w_cnt_nxt;
                            r_mem_a    <= r_mem_a + ADDR_WID'(1);
                            r_mem_dout <= w_next_byte;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_valid;
    logic        lsb_is_store;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_data;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_arbiter #(.ADDR_WID(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .if_valid       (if_valid),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .lsb_valid      (lsb_valid),
        .lsb_is_store   (lsb_is_store),
        .lsb_addr       (lsb_addr),
        .lsb_len        (lsb_len),
        .lsb_data       (lsb_data),
        .lsb_done       (lsb_done),
        .lsb_rdata      (lsb_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    typedef struct {
        bit          is_lsb;
        bit          has_data;
        logic [31:0] data;
        int          cyc;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    done_t      dq[$];
    wr_t        wq[$];
    logic [7:0] ram [0:65535];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_din <= ram[mem_a[15:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a, input int nb);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < nb; k++)
            w = w | (32'(ram[16'(a + 32'(k))]) << (8 * k));
        return w;
    endfunction

    // Done pulses and write beats are popped against bench-predicted events
    always @(negedge clk) begin
        done_t e;
        wr_t   w;
        if (rst === 1'b1) begin
            if (if_done === 1'b1 || lsb_done === 1'b1) begin
                chk("done_excl", 32'(if_done & lsb_done), 32'd0);
                if (dq.size() == 0) begin
                    chk("spurious_done", {30'd0, if_done, lsb_done}, 32'd0);
                end else begin
                    e = dq.pop_front();
                    chk("done_src", 32'(lsb_done), 32'(e.is_lsb));
                    chk("done_cyc", cyc, e.cyc);
                    if (e.has_data)
                        chk("done_data", lsb_done ? lsb_rdata : if_data, e.data);
                end
            end
            if (mem_wr === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("spurious_wr", 32'(mem_wr), 32'd0);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", mem_a, w.addr);
                    chk("wr_data", 32'(mem_dout), 32'(w.data));
                    chk("wr_cyc", cyc, w.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_mem_wr",    32'(mem_wr),    32'd0);
        chk("rst_mem_a",     mem_a,          32'd0);
        chk("rst_mem_dout",  32'(mem_dout),  32'd0);
        chk("rst_if_done",   32'(if_done),   32'd0);
        chk("rst_lsb_done",  32'(lsb_done),  32'd0);
        chk("rst_if_data",   if_data,        32'd0);
        chk("rst_lsb_rdata", lsb_rdata,      32'd0);
    endtask

    // Load or fetch; rdy is held low for gap_n cycles starting at byte gap_k's address cycle
    task automatic do_load(input bit is_if, input logic [31:0] addr, input logic [2:0] len_code,
                           input int nb, input int gap_k, input int gap_n);
        int t0;
        bit seen;
        t0 = cyc;
        if (is_if) begin
            if_valid = 1'b1;
            if_addr  = addr;
        end else begin
            lsb_valid    = 1'b1;
            lsb_is_store = 1'b0;
            lsb_addr     = addr;
            lsb_len      = len_code;
        end
        dq.push_back('{!is_if, 1'b1, rd_word(addr, nb), t0 + nb + 2 + gap_n});
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            step();
            rdy = !((c >= gap_k + 1) && (c <= gap_k + gap_n));
            if (gap_n == 0 && c <= nb)
                chk("ld_addr", mem_a, addr + 32'(c - 1));
            seen = is_if ? if_done : lsb_done;
        end
        chk("ld_done_seen", 32'(seen), 32'd1);
        if_valid  = 1'b0;
        lsb_valid = 1'b0;
        rdy       = 1'b1;
        step();
    endtask

    // Store; the gap is either rdy low or io_buffer_full high, rollback pulsed in cycle rb_cyc
    task automatic do_store(input logic [31:0] addr, input logic [2:0] len_code, input int nb,
                            input logic [31:0] data, input int gap_k, input int gap_n,
                            input bit gap_io, input int rb_cyc);
        int t0;
        bit seen;
        bit w_gap;
        t0 = cyc;
        lsb_valid    = 1'b1;
        lsb_is_store = 1'b1;
        lsb_addr     = addr;
        lsb_len      = len_code;
        lsb_data     = data;
        if (gap_io) io_buffer_full = 1'b1;
        for (int k = 0; k < nb; k++)
            wq.push_back('{addr + 32'(k), 8'(data >> (8 * k)), t0 + 1 + k + ((k >= gap_k) ? gap_n : 0)});
        dq.push_back('{1'b1, 1'b0, 32'd0, t0 + nb + 1 + gap_n});
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            step();
            w_gap = (c >= gap_k + 1) && (c <= gap_k + gap_n);
            if (gap_io) io_buffer_full = w_gap;
            else        rdy = !w_gap;
            rollback = (c == rb_cyc);
            seen = lsb_done;
            if (w_gap && !seen) begin
                @(negedge clk);
                chk("st_gap_wr", 32'(mem_wr), 32'd0);
            end
        end
        chk("st_done_seen", 32'(seen), 32'd1);
        lsb_valid = 1'b0;
        rollback  = 1'b0;
        rdy       = 1'b1;
        if (gap_io) io_buffer_full = 1'b0;
        step();
    endtask

    initial begin
        int t0;
        int n_done;
        bit seen;

        for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 37 + 11);
        ram[16'h1000] = 8'h13;
        ram[16'h1001] = 8'h05;
        ram[16'h1002] = 8'h00;
        ram[16'h1003] = 8'h00;

        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_valid = 1'b0; if_addr = '0;
        lsb_valid = 1'b0; lsb_is_store = 1'b0; lsb_addr = '0; lsb_len = 3'd0; lsb_data = '0;
        repeat (3) step();
        @(negedge clk);
        chk_reset_outs();
        rst = 1'b1;
        step();

        // Simultaneous requests straight after reset
        t0 = cyc;
        if_valid = 1'b1; if_addr = 32'h1000;
        lsb_valid = 1'b1; lsb_is_store = 1'b0; lsb_addr = 32'h2000; lsb_len = 3'd1;
        dq.push_back('{1'b1, 1'b1, rd_word(32'h2000, 1), t0 + 3});
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            step();
            seen = lsb_done;
        end
        chk("both_first_seen", 32'(seen), 32'd1);
        lsb_addr = 32'h2001;
`ifdef MEM_ARBITER_RR_EN
        dq.push_back('{1'b0, 1'b1, rd_word(32'h1000, 4), t0 + 10});
        dq.push_back('{1'b1, 1'b1, rd_word(32'h2001, 1), t0 + 14});
`else
        dq.push_back('{1'b1, 1'b1, rd_word(32'h2001, 1), t0 + 7});
        dq.push_back('{1'b0, 1'b1, rd_word(32'h1000, 4), t0 + 14});
`endif
        n_done = 0;
        for (int c = 1; c <= 40 && n_done < 2; c++) begin
            step();
            if (if_done)  begin if_valid  = 1'b0; n_done++; end
            if (lsb_done) begin lsb_valid = 1'b0; n_done++; end
        end
        chk("both_done_cnt", n_done, 2);
        if_valid = 1'b0; lsb_valid = 1'b0;
        step();

        do_load(1'b1, 32'h1000, 3'd0, 4, 0, 0);
        chk("fetch_word", if_data, 32'h0000_0513);

        do_store(32'h0003_0000, 3'd1, 1, 32'h0000_00AB, 0, 3, 1'b1, 0);

        // Rollback while fetch byte 2 is on the bus, then a fresh fetch
        t0 = cyc;
        if_valid = 1'b1; if_addr = 32'h1000;
        repeat (3) step();
        chk("rb_addr", mem_a, 32'h1002);
        rollback = 1'b1;
        @(negedge clk);
        chk("rb_wr", 32'(mem_wr), 32'd0);
        step();
        rollback = 1'b0;
        if_addr  = 32'h1004;
        dq.push_back('{1'b0, 1'b1, rd_word(32'h1004, 4), t0 + 10});
        step();
        chk("rb_restart_addr", mem_a, 32'h1004);
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            step();
            seen = if_done;
        end
        chk("rb_restart_seen", 32'(seen), 32'd1);
        if_valid = 1'b0;
        step();

        io_buffer_full = 1'b1;
        do_store(32'h0000_0100, 3'd4, 4, 32'h1122_3344, 0, 0, 1'b0, 2);
        io_buffer_full = 1'b0;

        do_store(32'h0000_0300, 3'd2, 2, 32'h0000_5566, 1, 1, 1'b0, 0);
        do_load(1'b0, 32'h2000, 3'd2, 2, 0, 1);
        do_load(1'b0, 32'hFFFF_FFFF, 3'd2, 2, 0, 0);
        do_load(1'b0, 32'h2008, 3'd3, 4, 0, 0);
        do_load(1'b0, 32'h200C, 3'd0, 4, 0, 0);

        // Reset in the middle of a word load
        lsb_valid = 1'b1; lsb_is_store = 1'b0; lsb_addr = 32'h2004; lsb_len = 3'd4;
        repeat (3) step();
        rst = 1'b0;
        lsb_valid = 1'b0;
        step();
        @(negedge clk);
        chk_reset_outs();
        rst = 1'b1;
        repeat (10) step();

        chk("dq_empty", dq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
